// File: rtl/uart_line_filter_if.sv
// Byte-stream handshake bundle between the UART FIFOs and the line filter.
// The filter is the slave: it consumes RX bytes and produces TX bytes.
interface uart_line_filter_if;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;
    logic [7:0] wdata;
    logic       wvalid;
    logic       wready;

    modport master (
        output rdata, rvalid, wready,
        input  rready, wdata, wvalid
    );

    modport slave (
        input  rdata, rvalid, wready,
        output rready, wdata, wvalid
    );
endinterface

// File: rtl/uart_line_filter.sv
// Classifies RX bytes, buffers the enabled ones into a line and replays the line
// on TX when a terminator arrives, with an optional hex length suffix and EOL.
module uart_line_filter #(
    parameter int DEPTH    = 64,
    parameter bit EOL_CRLF = 1'b1,
    parameter bit TERM_NUL = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    uart_line_filter_if.slave   bus,
    input  logic [7:0]          class_mask,
    input  logic                mode,
    output logic                busy,
    output logic                overflow,
    output logic [15:0]         line_count
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH_L = 8'(DEPTH);

    typedef enum logic [1:0] {COLLECT, EMIT, SUFFIX, EOL} state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  rd_ptr_q, rd_ptr_d;
    logic        line_ovf_q, line_ovf_d;
    logic        mode_q, mode_d;
    logic        overflow_q, overflow_d;
    logic [15:0] line_count_q, line_count_d;
    logic        rready_q, rready_d;
    logic [1:0]  sfx_idx_q, sfx_idx_d;
    logic        eol_idx_q, eol_idx_d;
    logic        buf_we;
    logic        wvalid_o;
    logic [7:0]  wdata_o;
    logic        is_term;
    logic        accept;

    logic [7:0]  line_buf_q [0:(1<<AW)-1];

    // Priority-ordered one-hot ASCII class; anything unmatched lands in bit7.
    function automatic logic [7:0] class_of(input logic [7:0] c);
        logic [7:0] cls;
        cls = 8'h80;
        if (c inside {[8'h61:8'h7A]})
            cls = 8'h01;
        else if (c inside {[8'h41:8'h5A]})
            cls = 8'h02;
        else if (c inside {[8'h30:8'h39]})
            cls = 8'h04;
        else if (c inside {8'h20, 8'h09})
            cls = 8'h08;
        else if (c inside {8'h2E, 8'h2C, 8'h3A, 8'h3B, 8'h21, 8'h3F, 8'h27, 8'h22})
            cls = 8'h10;
        else if (c inside {8'h23, 8'h24, 8'h25, 8'h26, 8'h40})
            cls = 8'h20;
        else if (c inside {8'h28, 8'h29, 8'h5B, 8'h5D, 8'h7B, 8'h7D})
            cls = 8'h40;
        return cls;
    endfunction

    function automatic logic [7:0] hex_digit(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign is_term = (bus.rdata == 8'h0D) || (bus.rdata == 8'h0A) ||
                     (TERM_NUL && (bus.rdata == 8'h00));
    assign accept  = rready_q && bus.rvalid;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        rd_ptr_d     = rd_ptr_q;
        line_ovf_d   = line_ovf_q;
        mode_d       = mode_q;
        overflow_d   = overflow_q;
        line_count_d = line_count_q;
        sfx_idx_d    = sfx_idx_q;
        eol_idx_d    = eol_idx_q;
        buf_we       = 1'b0;
        wvalid_o     = 1'b0;
        wdata_o      = 8'h00;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (is_term) begin
                        mode_d   = mode;
                        rd_ptr_d = 8'd0;
                        state_d  = EMIT;
                    end else if ((class_of(bus.rdata) & class_mask) != 8'h00) begin
                        if (len_q < DEPTH_L) begin
                            buf_we = 1'b1;
                            len_d  = len_q + 8'd1;
                        end else begin
                            overflow_d = 1'b1;
                            line_ovf_d = 1'b1;
                        end
                    end
                end
            end
            EMIT: begin
                // An exhausted (or empty) line moves on without presenting a byte.
                if (rd_ptr_q == len_q) begin
                    sfx_idx_d = 2'd0;
                    eol_idx_d = 1'b0;
                    state_d   = mode_q ? SUFFIX : EOL;
                end else begin
                    wvalid_o = 1'b1;
                    wdata_o  = line_buf_q[rd_ptr_q[AW-1:0]];
                    if (bus.wready)
                        rd_ptr_d = rd_ptr_q + 8'd1;
                end
            end
            SUFFIX: begin
                wvalid_o = 1'b1;
                case (sfx_idx_q)
                    2'd0:    wdata_o = 8'h20;
                    2'd1:    wdata_o = hex_digit(len_q[7:4]);
                    2'd2:    wdata_o = hex_digit(len_q[3:0]);
                    default: wdata_o = 8'h21;
                endcase
                if (bus.wready) begin
                    if ((sfx_idx_q == 2'd2 && !line_ovf_q) || sfx_idx_q == 2'd3) begin
                        eol_idx_d = 1'b0;
                        state_d   = EOL;
                    end else begin
                        sfx_idx_d = sfx_idx_q + 2'd1;
                    end
                end
            end
            EOL: begin
                wvalid_o = 1'b1;
                wdata_o  = (EOL_CRLF && !eol_idx_q) ? 8'h0D : 8'h0A;
                if (bus.wready) begin
                    if (!EOL_CRLF || eol_idx_q) begin
                        line_count_d = line_count_q + 16'd1;
                        len_d        = 8'd0;
                        line_ovf_d   = 1'b0;
                        state_d      = COLLECT;
                    end else begin
                        eol_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase

        // Dropping rready on the accepting edge keeps the next line in the RX FIFO.
        rready_d = (state_d == COLLECT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= COLLECT;
            len_q        <= 8'd0;
            rd_ptr_q     <= 8'd0;
            line_ovf_q   <= 1'b0;
            mode_q       <= 1'b0;
            overflow_q   <= 1'b0;
            line_count_q <= 16'd0;
            rready_q     <= 1'b0;
            sfx_idx_q    <= 2'd0;
            eol_idx_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rd_ptr_q     <= rd_ptr_d;
            line_ovf_q   <= line_ovf_d;
            mode_q       <= mode_d;
            overflow_q   <= overflow_d;
            line_count_q <= line_count_d;
            rready_q     <= rready_d;
            sfx_idx_q    <= sfx_idx_d;
            eol_idx_q    <= eol_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we)
            line_buf_q[len_q[AW-1:0]] <= bus.rdata;
    end

    assign bus.rready = rready_q;
    assign bus.wvalid = wvalid_o;
    assign bus.wdata  = wdata_o;
    assign busy       = (state_q != COLLECT);
    assign overflow   = overflow_q;
    assign line_count = line_count_q;

endmodule
